alu_op_dispatch: RTL
====================

// Module: alu_op_dispatch
// PURPOSE
//  Initiator side of the gated-operation unit interface. Accepts one command (opcode + two
//  operands) over a valid/ready handshake and drives operands plus a one-hot enable to the
//  addressed unit (AND, OR, ...). Waits SETTLE cycles, captures the unit's OUT_W-bit result and
//  returns it over a valid/ready result handshake. Sits between the top-level control/UI logic
//  and the bank of combinational op units.
// PARAMETERS
//  W          4  operand width (unit inputs a, b)
//  OUT_W      8  unit result width
//  NUM_UNITS  4  number of attached op units; legal opcodes 0..NUM_UNITS-1
//  SETTLE     1  cycles enable is held before capture; must be >=1 (elaboration error otherwise)
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               async active-low reset
//  cmd_valid  in   1               command present
//  cmd_ready  out  1               dispatcher idle, can accept
//  cmd_op     in   2               unit select
//  cmd_a      in   W               operand a
//  cmd_b      in   W               operand b
//  unit_en    out  NUM_UNITS       one-hot enable to units
//  unit_a     out  W               operand a to all units
//  unit_b     out  W               operand b to all units
//  unit_out   in   NUM_UNITS*OUT_W unit i result at [i*OUT_W +: OUT_W]
//  res_valid  out  1               result present
//  res_ready  in   1               consumer takes result
//  res_data   out  OUT_W           captured result
//  res_err    out  1               opcode was >= NUM_UNITS
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; unit_en=0, unit_a=0, unit_b=0, res_valid=0,
//    res_data=0, res_err=0, settle counter=0. cmd_ready=1 (decoded from IDLE).
//  - States: IDLE -> ISSUE -> HOLD -> IDLE. cmd_ready = (state==IDLE), combinational.
//  - IDLE: on edge with cmd_valid&cmd_ready: latch cmd_a/cmd_b into unit_a/unit_b, latch op,
//    load counter=SETTLE-1, go ISSUE. Legal op: unit_en = 1<<op. Illegal op: unit_en=0.
//  - ISSUE: unit_en, unit_a, unit_b stable. Counter !=0: decrement. Counter==0: on that edge
//    res_data <= unit_out slice of op (illegal op: 0), res_err <= illegal, res_valid <= 1,
//    unit_en <= 0, go HOLD.
//  - Latency: res_valid rises SETTLE edges after the accept edge (SETTLE=1: next edge).
//  - HOLD: res_valid, res_data, res_err frozen until res_valid&res_ready edge; then
//    res_valid <= 0, go IDLE. res_data/res_err keep last value after handshake.
//  - unit_a/unit_b keep last operands outside ISSUE; only unit_en gates the units.
//  - No overlap: cmd_ready low in ISSUE/HOLD; min command interval SETTLE+2 cycles
//    (res_ready held high).
//  - cmd inputs ignored when cmd_ready=0; res_ready ignored when res_valid=0.
//  - Result slice taken verbatim, full OUT_W bits; no sign/zero extension applied.
//  - Reset mid-ISSUE/HOLD: unit_en and res_valid drop immediately (async); command and
//    any pending result are discarded.
// CONFIGURATION
//  ALU_DISPATCH_ZERO_FLAG_EN defined: extra output port res_zero (1 bit), registered with
//    res_data, =1 when captured res_data==0 (also 1 for illegal op); reset 0; frozen in HOLD.
//  Undefined: port res_zero absent; no other behaviour change.
// TESTING  (bench: unit0 = gated AND, unit1 = gated OR, NUM_UNITS=4, SETTLE=1 unless noted)
//  - op=0 a=4'hC b=4'hA, res_ready=1 -> unit_en=4'b0001 one cycle; res_data=8'h08,
//    res_err=0, res_valid 1 edge after accept.
//  - op=1 a=4'h5 b=4'hA, res_ready low 5 cycles -> res_valid/res_data=8'h0F stable all 5;
//    cmd_ready=0 throughout; IDLE one edge after res_ready rises.
//  - NUM_UNITS=3, op=3 -> unit_en stays 0; res_data=8'h00, res_err=1.
//  - SETTLE=3, op=0 a=4'hF b=4'h3 -> unit_en high 3 cycles; res_data=8'h03 on 3rd edge.
//  - rst_n low during ISSUE -> unit_en=0, res_valid=0 same cycle; after release cmd_ready=1,
//    no stale result emitted.
//  - ALU_DISPATCH_ZERO_FLAG_EN: op=0 a=4'h5 b=4'hA -> res_data=8'h00, res_zero=1;
//    then a=4'h1 b=4'h1 -> res_zero=0.

Source files
------------

// File: rtl/alu_op_dispatch.sv
// Command dispatcher for a bank of gated op units: one command in, one captured result out.
// Optional feature: define ALU_DISPATCH_ZERO_FLAG_EN to add the res_zero output.
module alu_op_dispatch #(
    parameter int W         = 4,
    parameter int OUT_W     = 8,
    parameter int NUM_UNITS = 4,
    parameter int SETTLE    = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [W-1:0]               cmd_a,
    input  logic [W-1:0]               cmd_b,
    output logic [NUM_UNITS-1:0]       unit_en,
    output logic [W-1:0]               unit_a,
    output logic [W-1:0]               unit_b,
    input  logic [NUM_UNITS*OUT_W-1:0] unit_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [OUT_W-1:0]           res_data,
    output logic                       res_err
`ifdef ALU_DISPATCH_ZERO_FLAG_EN
    ,
    output logic                       res_zero
`endif
);

    if (SETTLE < 1) begin : g_bad_settle
        $error("alu_op_dispatch: SETTLE must be >= 1");
    end

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             op_q, op_d;
    logic [NUM_UNITS-1:0]   en_q, en_d;
    logic [W-1:0]           a_q, a_d, b_q, b_d;
    logic                   valid_q, valid_d;
    logic [OUT_W-1:0]       data_q, data_d;
    logic                   err_q, err_d;
    logic                   zero_q, zero_d;
    logic                   cmd_legal, op_legal;
    logic [OUT_W-1:0]       sel_out;

    assign cmd_legal = (int'(cmd_op) < NUM_UNITS);
    assign op_legal  = (int'(op_q) < NUM_UNITS);

    // Illegal opcodes never match a slice, so they capture zero.
    always_comb begin
        sel_out = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (int'(op_q) == i) sel_out = unit_out[i*OUT_W +: OUT_W];
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // cmd_ready is high only in IDLE, res_valid holds with stable data until res_ready.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        en_d    = en_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    op_d    = cmd_op;
                    cnt_d   = CW'(SETTLE - 1);
                    en_d    = cmd_legal ? (NUM_UNITS'(1) << cmd_op) : '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    data_d  = sel_out;
                    err_d   = !op_legal;
                    zero_d  = (sel_out == '0);
                    valid_d = 1'b1;
                    en_d    = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            en_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            en_q    <= en_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign unit_en   = en_q;
    assign unit_a    = a_q;
    assign unit_b    = b_q;
    assign res_valid = valid_q;
    assign res_data  = data_q;
    assign res_err   = err_q;
`ifdef ALU_DISPATCH_ZERO_FLAG_EN
    assign res_zero  = zero_q;
`else
    logic unused_zero;
    assign unused_zero = zero_q;
`endif

endmodule
